// File: rtl/cache_fill_ctrl.sv
// Miss-side fill controller for a 4-way set-associative cache: picks a victim,
// fetches the line word over a valid/ready handshake, and writes it back.
module cache_fill_ctrl #(
    parameter int NUM_SETS = 64,
    parameter int IDX_W    = $clog2(NUM_SETS),
    parameter int TAG_W    = 32 - IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             miss_valid,
    output logic             miss_ready,
    input  logic [31:0]      miss_addr,
    input  logic             access_valid,
    input  logic [IDX_W-1:0] access_set,
    input  logic [1:0]       access_way,
    input  logic             flush,
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic [31:0]      mem_req_addr,
    input  logic             mem_rsp_valid,
    input  logic [31:0]      mem_rsp_data,
    output logic [3:0]       way_we,
    output logic [IDX_W-1:0] wr_set,
    output logic [TAG_W-1:0] wr_tag,
    output logic [31:0]      wr_data,
    output logic             fill_done,
    output logic [1:0]       fill_way,
    output logic [3:0]       valid_q
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, WRITE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [31:0]      addr_r;
    logic [31:0]      data_r;
    logic [1:0]       victim_r;
    logic [3:0]       valid_r [NUM_SETS];
    logic [2:0]       plru_r  [NUM_SETS];
    logic [IDX_W-1:0] miss_set;
    logic [3:0]       miss_vbits;
    logic [2:0]       miss_plru;
    logic [1:0]       victim;
    logic             capture;
    logic             write;

    // Tree PLRU touch: bit 0 is the root, bit 1 covers ways 0/1, bit 2 covers ways 2/3.
    function automatic logic [2:0] plru_touch(input logic [2:0] bits, input logic [1:0] way);
        logic [2:0] res;
        res = bits;
        if (!way[1]) begin
            res[0] = 1'b1;
            res[1] = ~way[0];
        end else begin
            res[0] = 1'b0;
            res[2] = ~way[0];
        end
        return res;
    endfunction

    assign miss_set   = miss_addr[IDX_W-1:0];
    assign miss_vbits = valid_r[miss_set];
    assign miss_plru  = plru_r[miss_set];

    always_comb begin
        victim = 2'd0;
        if (!miss_vbits[0])      victim = 2'd0;
        else if (!miss_vbits[1]) victim = 2'd1;
        else if (!miss_vbits[2]) victim = 2'd2;
        else if (!miss_vbits[3]) victim = 2'd3;
        else if (miss_plru[0])   victim = miss_plru[2] ? 2'd3 : 2'd2;
        else                     victim = miss_plru[1] ? 2'd1 : 2'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (miss_valid) begin
                    state_nxt = REQ;
                    capture   = 1'b1;
                end
            end
            REQ:     if (mem_req_ready) state_nxt = WAIT;
            WAIT:    if (mem_rsp_valid) state_nxt = WRITE;
            WRITE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign write         = (state == WRITE);
    assign miss_ready    = (state == IDLE);
    assign mem_req_valid = (state == REQ);
    assign mem_req_addr  = addr_r;
    assign way_we        = write ? (4'b0001 << victim_r) : 4'b0000;
    assign wr_set        = addr_r[IDX_W-1:0];
    assign wr_tag        = addr_r[31:IDX_W];
    assign wr_data       = data_r;
    assign fill_done     = write;
    assign fill_way      = victim_r;
    assign valid_q       = valid_r[access_set];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r   <= '0;
            data_r   <= '0;
            victim_r <= '0;
        end else begin
            if (capture) begin
                addr_r   <= miss_addr;
                victim_r <= victim;
            end
            if (state == WAIT && mem_rsp_valid) data_r <= mem_rsp_data;
        end
    end

    // A hit to the set being filled is dropped so the fill touch decides that set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_r[s] <= '0;
                plru_r[s]  <= '0;
            end
        end else begin
            if (access_valid && !(write && access_set == wr_set))
                plru_r[access_set] <= plru_touch(plru_r[access_set], access_way);
            if (write)
                plru_r[wr_set] <= plru_touch(plru_r[wr_set], victim_r);
            if (flush) begin
                for (int s = 0; s < NUM_SETS; s++) valid_r[s] <= '0;
            end else if (write) begin
                valid_r[wr_set][victim_r] <= 1'b1;
            end
        end
    end

endmodule
